// File: rtl/agc_stage_branch_seq.sv
// AGC stage/branch sequencer: timepulse ring, stage register, divide sequencing, BR1/BR2 flags.
// Optional STG_CHECK_EN macro builds the sticky err_conflict checker; otherwise err_conflict is 0.
module agc_stage_branch_seq #(
  parameter int unsigned STAGE_W   = 3,
  parameter int unsigned NTP       = 12,
  parameter int unsigned DIV_STEPS = 4
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               mct_start,
  input  logic               st1_req,
  input  logic               st2_req,
  input  logic               dvst,
  input  logic               rststg,
  input  logic               tsgn,
  input  logic               tov,
  input  logic               tmz,
  input  logic               sign,
  input  logic               ovf_pos,
  input  logic               ovf_neg,
  input  logic               mz,
  output logic [NTP-1:0]     tp,
  output logic               mct_end,
  output logic [STAGE_W-1:0] stg,
  output logic               div_active,
  output logic               div_done,
  output logic               br1,
  output logic               br2,
  output logic               br12b,
  output logic               err_conflict
);

  localparam logic [NTP-1:0]     T01      = NTP'(1);
  localparam logic [STAGE_W-1:0] DIV_LAST = STAGE_W'(DIV_STEPS - 1);

  typedef enum logic {S_NORM = 1'b0, S_DIV = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] pend;
  logic       pend_dv;
  logic [1:0] pend_eff;
  logic       pend_dv_eff;
  logic       div_last;

  // Requests seen this cycle are folded in so an mct_end-cycle request lands in the same update.
  assign pend_eff    = pend | (div_active ? 2'b00 : {st2_req, st1_req});
  assign pend_dv_eff = pend_dv | dvst;
  assign div_last    = (stg == DIV_LAST);
  assign mct_end     = tp[NTP-1];
  assign br12b       = ~(br1 | br2);

  // Timepulse ring: idle at zero until the first mct_start, then free-running.
  always_ff @(posedge CLOCK) begin
    if (rst)            tp <= '0;
    else if (mct_start) tp <= T01;
    else if (|tp)       tp <= {tp[NTP-2:0], tp[NTP-1]};
  end

  always_ff @(posedge CLOCK) begin
    if (rst) state <= S_NORM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rststg) begin
      state_nxt = S_NORM;
    end else if (mct_end) begin
      case (state)
        S_NORM: if (pend_dv_eff) state_nxt = S_DIV;
        S_DIV:  if (div_last)    state_nxt = S_NORM;
        default: state_nxt = S_NORM;
      endcase
    end
  end

  always_comb begin
    div_active = (state == S_DIV);
  end

  // Stage register doubles as the divide step counter while div_active.
  always_ff @(posedge CLOCK) begin
    if (rst || rststg) begin
      stg      <= '0;
      pend     <= '0;
      pend_dv  <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (mct_end) begin
        pend    <= '0;
        pend_dv <= 1'b0;
        if (div_active) begin
          if (div_last) begin
            stg      <= '0;
            div_done <= 1'b1;
          end else begin
            stg <= stg + STAGE_W'(1);
          end
        end else if (pend_dv_eff) begin
          stg <= '0;
        end else begin
          stg <= STAGE_W'(pend_eff);
        end
      end else begin
        pend    <= pend_eff;
        pend_dv <= pend_dv_eff;
      end
    end
  end

  // Branch flags: tov beats tsgn on br1, tmz beats tov on br2.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      br1 <= 1'b0;
      br2 <= 1'b0;
    end else begin
      if (tov)       br1 <= ovf_pos;
      else if (tsgn) br1 <= sign;
      if (tmz)       br2 <= mz;
      else if (tov)  br2 <= ovf_neg;
    end
  end

`ifdef STG_CHECK_EN
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      err_conflict <= 1'b0;
    end else if ((div_active && (st1_req || st2_req)) || (dvst && rststg)) begin
      err_conflict <= 1'b1;
    end
  end
`else
  assign err_conflict = 1'b0;
`endif

endmodule
